// File: rtl/jam_pkg.sv
// Shared constants and the controller state type for the job-assignment cost server.
package jam_pkg;

  localparam int N          = 8;
  localparam int COST_W     = 7;
  localparam int MINCOST_W  = 10;
  localparam int COUNT_W    = 4;
  localparam int CHECKSUM_W = 13;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/jam_cost_table.sv
// Cost register file: one write port and a registered read port.
// Storage is left unreset because every load rewrites it.
module jam_cost_table
  import jam_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = COST_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/jam_cost_server.sv
// Loads an N x N cost table, serves registered lookups to a solver and captures its result.
// Optional JAM_CHECKSUM_EN adds a running sum of accepted load words on checksum.
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int N      = jam_pkg::N,
  parameter int COST_W = jam_pkg::COST_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  input  logic [COST_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  table_ready,
  input  logic [2:0]            W,
  input  logic [2:0]            J,
  output logic [COST_W-1:0]     Cost,
  input  logic                  Valid,
  input  logic [MINCOST_W-1:0]  MinCost,
  input  logic [COUNT_W-1:0]    MatchCount,
  output logic                  done,
  output logic [MINCOST_W-1:0]  res_cost,
  output logic [COUNT_W-1:0]    res_count,
  input  logic                  restart,
  output logic [CHECKSUM_W-1:0] checksum
);

  localparam int         DEPTH    = N * N;
  localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

  state_t     state;
  logic [5:0] idx;
  logic       accept;
  logic       serving;

  // restart has priority over a load word arriving in the same cycle
  assign accept  = (state == LOAD) && in_valid && !restart;
  assign serving = (state == SERVE) || (state == DONE);

  jam_cost_table #(
    .DEPTH  (DEPTH),
    .DATA_W (COST_W),
    .ADDR_W (6)
  ) u_table (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (accept),
    .wr_addr (idx),
    .wr_data (in_data),
    .rd_en   (serving),
    .rd_addr ({W, J}),
    .rd_data (Cost)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= LOAD;
      idx         <= '0;
      in_ready    <= 1'b1;
      table_ready <= 1'b0;
      done        <= 1'b0;
      res_cost    <= '0;
      res_count   <= '0;
    end else begin
      done <= 1'b0;
      if (restart) begin
        state       <= LOAD;
        idx         <= '0;
        in_ready    <= 1'b1;
        table_ready <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (in_valid) begin
              idx <= idx + 6'd1;
              if (idx == LAST_IDX) begin
                state       <= SERVE;
                in_ready    <= 1'b0;
                table_ready <= 1'b1;
              end
            end
          end
          SERVE: begin
            if (Valid) begin
              res_cost  <= MinCost;
              res_count <= MatchCount;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= LOAD;
          end
        endcase
      end
    end
  end

`ifdef JAM_CHECKSUM_EN
  // Wraps naturally at 2^13; a full table of maximum costs still fits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      checksum <= '0;
    end else if (restart) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + CHECKSUM_W'(in_data);
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Randomised and directed bench for jam_cost_server against an abstract table/phase model.
module tb_jam_cost_server;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic [6:0]  in_data;
  logic        in_ready;
  logic        table_ready;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic        Valid;
  logic [9:0]  MinCost;
  logic [3:0]  MatchCount;
  logic        done;
  logic [9:0]  res_cost;
  logic [3:0]  res_count;
  logic        restart;
  logic [12:0] checksum;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  jam_cost_server dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .table_ready (table_ready),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .Valid       (Valid),
    .MinCost     (MinCost),
    .MatchCount  (MatchCount),
    .done        (done),
    .res_cost    (res_cost),
    .res_count   (res_count),
    .restart     (restart),
    .checksum    (checksum)
  );

  always #5 CLK = ~CLK;

  // Reference: words loaded so far, table contents, capture flag, running sum.
  int m_table [64];
  int m_count;
  bit m_captured;
  bit m_cost_valid;
  int m_cost;
  int m_res_cost;
  int m_res_count;
  int m_sum;
  bit m_done;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_count      = 0;
      m_captured   = 0;
      m_cost_valid = 1;
      m_cost       = 0;
      m_res_cost   = 0;
      m_res_count  = 0;
      m_sum        = 0;
      m_done       = 0;
    end else begin
      m_done = 0;
      if (m_count == 64) begin
        m_cost       = m_table[int'(W) * 8 + int'(J)];
        m_cost_valid = 1;
      end
      if (restart) begin
        m_count      = 0;
        m_captured   = 0;
        m_cost_valid = 0;
        m_sum        = 0;
      end else if (m_count < 64) begin
        if (in_valid) begin
          m_table[m_count] = int'(in_data);
          m_count++;
          m_sum = (m_sum + int'(in_data)) % 8192;
        end
      end else if (!m_captured && Valid) begin
        m_captured  = 1;
        m_res_cost  = int'(MinCost);
        m_res_count = int'(MatchCount);
        m_done      = 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_checksum(input int sum);
`ifdef JAM_CHECKSUM_EN
    return sum;
`else
    return 0 * sum;
`endif
  endfunction

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("in_ready", int'(in_ready), int'(m_count < 64));
      check("table_ready", int'(table_ready), int'(m_count == 64));
      check("done", int'(done), int'(m_done));
      check("res_cost", int'(res_cost), m_res_cost);
      check("res_count", int'(res_count), m_res_count);
      check("checksum", int'(checksum), exp_checksum(m_sum));
      if (m_cost_valid) check("cost", int'(Cost), m_cost);
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input bit iv, input int data, input bit rs);
    in_valid = iv;
    in_data  = 7'(data);
    restart  = rs;
    tick();
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    check(name, act, exp);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_cost", int'(Cost), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_res_cost", int'(res_cost), 0);
    checkOutput("rst_res_count", int'(res_count), 0);
    checkOutput("rst_checksum", int'(checksum), 0);
    checkOutput("rst_table_ready", int'(table_ready), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    RST = 1'b0; in_valid = 1'b0; in_data = '0; W = '0; J = '0;
    Valid = 1'b0; MinCost = '0; MatchCount = '0; restart = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    checkResetValues();
    RST = 1'b1;
    tick();

    // Table of i % 100, then two lookups
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, i % 100, 1'b0);
    checkOutput("load_table_ready", int'(table_ready), 1);
    checkOutput("load_in_ready", int'(in_ready), 0);
    W = 3'd3; J = 3'd5; tick();
    checkOutput("cost_3_5", int'(Cost), 29);
    W = 3'd7; J = 3'd7; tick();
    checkOutput("cost_7_7", int'(Cost), 63);

    // Capture, then a second Valid is ignored
    Valid = 1'b1; MinCost = 10'd247; MatchCount = 4'd2; tick();
    Valid = 1'b0;
    checkOutput("cap_done", int'(done), 1);
    checkOutput("cap_res_cost", int'(res_cost), 247);
    checkOutput("cap_res_count", int'(res_count), 2);
    tick();
    checkOutput("cap_done_pulse", int'(done), 0);
    Valid = 1'b1; MinCost = 10'd100; MatchCount = 4'd9; tick();
    Valid = 1'b0;
    checkOutput("second_done", int'(done), 0);
    checkOutput("second_res_cost", int'(res_cost), 247);
    checkOutput("second_res_count", int'(res_count), 2);

    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("restart_table_ready", int'(table_ready), 0);
    checkOutput("restart_in_ready", int'(in_ready), 1);

    // 70 back-to-back words: only 64 land, word 0 survives
    for (int k = 0; k < 70; k++) begin
      applyStimulus(1'b1, (k == 0) ? 17 : int'($urandom_range(0, 127)), 1'b0);
      if (k == 63) checkOutput("overflow_in_ready", int'(in_ready), 0);
    end
    W = 3'd0; J = 3'd0; tick();
    checkOutput("overflow_cost_0", int'(Cost), 17);

    // restart collides with Valid in SERVE
    Valid = 1'b1; MinCost = 10'd300; restart = 1'b1; tick();
    Valid = 1'b0; restart = 1'b0;
    checkOutput("collide_done", int'(done), 0);
    checkOutput("collide_table_ready", int'(table_ready), 0);
    checkOutput("collide_checksum", int'(checksum), 0);
    tick();
    checkOutput("collide_done_late", int'(done), 0);

    // Reset mid-load, then a full reload of 127s
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, int'($urandom_range(0, 127)), 1'b0);
    RST = 1'b0;
    #1;
    checkResetValues();
    tick();
    RST = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 127, 1'b0);
    checkOutput("reload_table_ready", int'(table_ready), 1);
`ifdef JAM_CHECKSUM_EN
    checkOutput("sum_127", int'(checksum), 8128);
`else
    checkOutput("sum_127", int'(checksum), 0);
`endif
    W = 3'd4; J = 3'd2; tick();
    checkOutput("reload_cost", int'(Cost), 127);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("sum_after_restart", int'(checksum), 0);

    // Random traffic, the model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(0, 9) < 8);
      in_data    = 7'($urandom_range(0, 127));
      W          = 3'($urandom_range(0, 7));
      J          = 3'($urandom_range(0, 7));
      Valid      = ($urandom_range(0, 19) == 0);
      MinCost    = 10'($urandom_range(0, 1023));
      MatchCount = 4'($urandom_range(0, 15));
      restart    = ($urandom_range(0, 199) == 0);
      RST        = ($urandom_range(0, 499) != 0);
      tick();
    end
    RST = 1'b1; in_valid = 1'b0; Valid = 1'b0; restart = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
